// File: rtl/pump_rotator.sv
// Lead-pump rotation controller for N pumps.
// Runs at most one pump and rotates the duty pump round-robin.
module pump_rotator #(
    parameter int N_PUMPS = 4,
    parameter int MAX_RUN = 8,
    parameter int GAP     = 2,
    parameter int IDX_W   = $clog2(N_PUMPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               demand,
    input  logic [N_PUMPS-1:0] fault,
    output logic [N_PUMPS-1:0] pump_on,
    output logic [IDX_W-1:0]   active_idx,
    output logic               alarm
);

    localparam int RW = $clog2(MAX_RUN);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [RW-1:0] RUN_LAST = RW'(MAX_RUN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HANDOVER,
        ALARM
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  next_ptr;
    logic [IDX_W-1:0]  next_ptr_next;
    logic [IDX_W-1:0]  active_next;
    logic [RW-1:0]     run_cnt;
    logic [RW-1:0]     run_cnt_next;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_cnt_next;

    logic              ptr_found;
    logic [IDX_W-1:0]  ptr_pick;
    logic              rot_found;
    logic [IDX_W-1:0]  rot_pick;
    logic [IDX_W-1:0]  after_active;
    logic              rotate;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        if (int'(p) == N_PUMPS - 1) begin
            return '0;
        end
        return p + IDX_W'(1);
    endfunction

    // Returns {found, index} of the first healthy pump in span slots from start.
    function automatic logic [IDX_W:0] search(
        input logic [IDX_W-1:0]   start,
        input logic [N_PUMPS-1:0] flt,
        input int                 span
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_PUMPS; k++) begin
            j = int'(start) + k;
            if (j >= N_PUMPS) begin
                j = j - N_PUMPS;
            end
            if (k < span && !found && !flt[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        after_active           = wrap_inc(active_idx);
        {ptr_found, ptr_pick}  = search(next_ptr, fault, N_PUMPS);
        {rot_found, rot_pick}  = search(after_active, fault, N_PUMPS - 1);
        rotate                 = fault[active_idx] || (run_cnt == RUN_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            next_ptr   <= '0;
            active_idx <= '0;
            run_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_next;
            next_ptr   <= next_ptr_next;
            active_idx <= active_next;
            run_cnt    <= run_cnt_next;
            gap_cnt    <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        next_ptr_next = next_ptr;
        active_next   = active_idx;
        run_cnt_next  = run_cnt;
        gap_cnt_next  = gap_cnt;
        unique case (state)
            IDLE: begin
                if (demand) begin
                    if (ptr_found) begin
                        state_next   = RUN;
                        active_next  = ptr_pick;
                        run_cnt_next = '0;
                    end else begin
                        state_next = ALARM;
                    end
                end
            end
            RUN: begin
                run_cnt_next = run_cnt + RW'(1);
                if (!demand) begin
                    state_next    = IDLE;
                    next_ptr_next = after_active;
                end else if (rotate) begin
                    if (rot_found) begin
                        next_ptr_next = rot_pick;
                        if (GAP > 0) begin
                            state_next   = HANDOVER;
                            gap_cnt_next = '0;
                        end else begin
                            active_next  = rot_pick;
                            run_cnt_next = '0;
                        end
                    end else if (fault[active_idx]) begin
                        state_next    = ALARM;
                        next_ptr_next = after_active;
                    end else begin
                        // Sole healthy pump: keep it running, restart the limit.
                        run_cnt_next = '0;
                    end
                end
            end
            HANDOVER: begin
                if (!demand) begin
                    state_next = IDLE;
                end else if (gap_cnt == GAP_LAST) begin
                    if (ptr_found) begin
                        state_next   = RUN;
                        active_next  = ptr_pick;
                        run_cnt_next = '0;
                    end else begin
                        state_next = ALARM;
                    end
                end else begin
                    gap_cnt_next = gap_cnt + GW'(1);
                end
            end
            ALARM: begin
                if (!demand) begin
                    state_next = IDLE;
                end else if (ptr_found) begin
                    state_next   = RUN;
                    active_next  = ptr_pick;
                    run_cnt_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pump_on = '0;
        alarm   = 1'b0;
        if (state == RUN) begin
            pump_on[active_idx] = 1'b1;
        end
        if (state == ALARM) begin
            alarm = 1'b1;
        end
    end

endmodule

// File: doc/pump_rotator.md
# pump_rotator

Parametrised lead-pump rotation controller for the pumping station, generalising the two-pump alternation queue to N pumps. It drives at most one pump at a time on demand and rotates the duty pump round-robin so wear is shared. Rotation happens on demand release, on a run-time limit and on pump fault, with a configurable dead gap between pumps. It sits between the demand/level logic and the pump contactor drivers, and raises an alarm when demand cannot be served.

## Interface
- N_PUMPS, 4, number of pumps (≥2); IDX_W = $clog2(N_PUMPS)
- MAX_RUN, 8, maximum consecutive cycles one pump may run before forced rotation (≥2)
- GAP, 2, all-off cycles inserted at every pump-to-pump handover (0 = direct switch)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- demand  in  1  level request for pumping
- fault  in  N_PUMPS  bit i = 1: pump i unavailable
- pump_on  out  N_PUMPS  one-hot run command, or all zero
- active_idx  out  IDX_W  pump currently running, or last pump run
- alarm  out  1  demand present but no healthy pump

## Operation
- States: IDLE, RUN, HANDOVER, ALARM. All outputs are registered (Moore).
- Internal registers: next_ptr (IDX_W), run_cnt (width $clog2(MAX_RUN)), gap_cnt (width $clog2(GAP+1)).
- Search function: from pointer p, pick the first i in p, p+1, …, wrapping mod N_PUMPS, with fault[i]=0. Used combinationally on the current fault vector.
- IDLE: pump_on=0.
  - demand=1 and a healthy pump is found from next_ptr → RUN on that pump; run_cnt=0.
  - demand=1 and no healthy pump → ALARM.
- RUN: pump_on has bit active_idx set; run_cnt increments each cycle.
  - demand=0 → IDLE, pumps off, next_ptr=active_idx+1 mod N.
  - fault[active_idx]=1, or run_cnt==MAX_RUN-1 → rotate. Target = search from active_idx+1, excluding active_idx.
    - Target exists: with GAP>0, go to HANDOVER with pumps off; with GAP=0, switch directly to RUN on the target with run_cnt=0.
    - No target, limit case: the pump keeps running and run_cnt restarts at 0.
    - No target, fault case: ALARM.
- HANDOVER: pump_on=0; next_ptr holds the target; gap_cnt counts GAP cycles.
  - demand=0 → IDLE, next_ptr retained.
  - After GAP cycles, search from next_ptr. Healthy pump found → RUN, active_idx updated. Otherwise → ALARM.
- ALARM: pump_on=0, alarm=1.
  - demand=0 → IDLE, alarm cleared.
  - Any healthy pump found from next_ptr → RUN, alarm cleared.
- Priority in RUN: demand=0 over fault, and fault over run limit.
- reset overrides everything, including mid-HANDOVER and ALARM.

## Timing
- Reset values: pump_on=0, active_idx=0, alarm=0, next_ptr=0, run_cnt=0, gap_cnt=0, state IDLE.
- Start latency: demand sampled high at edge k → pump_on valid after edge k.
- Run limit: a pump stays on for exactly MAX_RUN cycles, then pumps are off for exactly GAP cycles, then the next pump turns on.
- Stop latency: demand low at edge k → pump_on=0 after edge k.
- Fault on the active pump: pump off after the sampling edge, with the same GAP rule as a limit rotation.
- No two pump_on bits are ever high in the same cycle.
- Fault changes during HANDOVER are honoured at the end-of-gap search.

## Test plan
- Reset, then demand=1 held, fault=0, N=4, MAX_RUN=8, GAP=2 → pump_on sequence 0001×8, 0000×2, 0010×8, 0000×2, 0100×8, … wrapping 1000 → 0001; alarm=0 throughout.
- Pump 0 running, demand drops after 3 cycles, then rises 5 cycles later → pump_on=0 the cycle after the drop; on restart pump_on=0010, active_idx=1.
- Pump 1 running, fault=0010 asserted → off next cycle, 2 gap cycles, then pump_on=0100; with fault=0110, pump_on=1000 instead.
- fault=1110, demand held → pump 0 runs continuously past MAX_RUN (no rotation, no gap); then set fault=1111 → pump_on=0, alarm=1; clear fault bit 2 → pump_on=0100, alarm=0.
- Demand drops during HANDOVER to pump 2, then reasserts → pump_on=0100 one cycle after reassertion.
- reset pulsed mid-RUN on pump 3 and during ALARM → all outputs return to reset values the cycle after; the next start uses pump 0.
